// File: rtl/cga_composite.sv
// Composite video encoder for the CGA pixel stream: mixes luma and square-wave chroma,
// and builds sync, breezeway, colour burst and blanking around the CRTC syncs.
module cga_composite #(
  parameter int unsigned SYNC_CLKS   = 270,
  parameter int unsigned BREEZE_CLKS = 34,
  parameter int unsigned BURST_CLKS  = 144,
  parameter logic [6:0]  SYNC_LVL    = 7'd0,
  parameter logic [6:0]  BLANK_LVL   = 7'd32,
  parameter logic [6:0]  I_STEP      = 7'd24,
  parameter logic [6:0]  WHITE_STEP  = 7'd40,
  parameter logic [6:0]  CHROMA_STEP = 7'd20,
  parameter logic [6:0]  BURST_AMP   = 7'd12,
  parameter logic [3:0]  BURST_PHASE = 4'd4
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [3:0] video,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       color_kill,
  output logic [6:0] comp_video,
  output logic       burst_active
);

  localparam logic [8:0] SyncInit   = 9'(SYNC_CLKS - 1);
  localparam logic [8:0] BreezeInit = 9'(BREEZE_CLKS - 1);
  localparam logic [8:0] BurstInit  = 9'(BURST_CLKS - 1);

  typedef enum logic [2:0] {
    StActive, StSync, StBreeze, StBurst, StBlank, StVsync
  } state_e;

  logic [3:0] ph_q, ph_s1_q, video_q;
  logic       hs_q, hs_qq, vs_q, vs_qq, ck_q;
  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       hs_rise, vs_rise;
  logic [3:0] hue, pix_ph, burst_ph;
  logic [8:0] pix_sum;
  logic [6:0] pix_lvl, chroma_add, cv_d;
  logic       ba_d;

  // Stage 1: input capture; the phase is sampled alongside so one pixel sees one phase.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ph_q    <= 4'd0;
      ph_s1_q <= 4'd0;
      video_q <= 4'd0;
      hs_q    <= 1'b0;
      hs_qq   <= 1'b0;
      vs_q    <= 1'b0;
      vs_qq   <= 1'b0;
      ck_q    <= 1'b0;
    end else begin
      ph_q    <= ph_q + 4'd1;
      ph_s1_q <= ph_q;
      video_q <= video;
      hs_q    <= hsync;
      hs_qq   <= hs_q;
      vs_q    <= vsync;
      vs_qq   <= vs_q;
      ck_q    <= color_kill;
    end
  end

  assign hs_rise = hs_q & ~hs_qq;
  assign vs_rise = vs_q & ~vs_qq;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (vs_rise) begin
      state_d = StVsync;
    end else if (hs_rise && state_q != StVsync) begin
      state_d = StSync;
      cnt_d   = SyncInit;
    end else begin
      case (state_q)
        StSync: begin
          if (cnt_q == 9'd0) begin
            state_d = StBreeze;
            cnt_d   = BreezeInit;
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
        StBreeze: begin
          if (cnt_q == 9'd0) begin
            state_d = StBurst;
            cnt_d   = BurstInit;
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
        StBurst: begin
          if (cnt_q == 9'd0) state_d = StBlank;
          else               cnt_d   = cnt_q - 9'd1;
        end
        StBlank: if (!hs_q) state_d = StActive;
        StVsync: if (!vs_q) state_d = StBlank;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (video_q[2:0])
      3'b001:  hue = 4'd8;
      3'b010:  hue = 4'd12;
      3'b011:  hue = 4'd10;
      3'b100:  hue = 4'd2;
      3'b101:  hue = 4'd0;
      3'b110:  hue = 4'd4;
      default: hue = 4'd0;
    endcase
  end

  assign pix_ph   = ph_s1_q + hue;
  assign burst_ph = ph_s1_q + BURST_PHASE;

  always_comb begin
    chroma_add = 7'd0;
    if (video_q[2:0] == 3'b111)                            chroma_add = WHITE_STEP;
    else if (video_q[2:0] != 3'b000 && !ck_q && !pix_ph[3]) chroma_add = CHROMA_STEP;
    pix_sum = {2'b00, BLANK_LVL} + (video_q[3] ? {2'b00, I_STEP} : 9'd0)
            + {2'b00, chroma_add};
    pix_lvl = (pix_sum > 9'd127) ? 7'd127 : pix_sum[6:0];
  end

  // Output is decoded from the next state so the whole path stays at two clocks.
  always_comb begin
    ba_d = 1'b0;
    case (state_d)
      StActive:        cv_d = pix_lvl;
      StSync, StVsync: cv_d = SYNC_LVL;
      StBurst: begin
        if (ck_q) begin
          cv_d = BLANK_LVL;
        end else begin
          ba_d = 1'b1;
          cv_d = burst_ph[3] ? (BLANK_LVL - BURST_AMP) : (BLANK_LVL + BURST_AMP);
        end
      end
      default:         cv_d = BLANK_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= StBlank;
      cnt_q        <= 9'd0;
      comp_video   <= BLANK_LVL;
      burst_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      comp_video   <= cv_d;
      burst_active <= ba_d;
    end
  end

endmodule
